subtractor_16bit_serial: RTL



---
 rtl/alu_pkg.sv | 30 +++
 rtl/sub_slice_8bit.sv | 19 +
 rtl/subtractor_16bit_serial.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: word/slice widths and the serial-subtractor
// sequencing states.
package alu_pkg;

    localparam int WORD_W  = 16;
    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    // Operation captured on the accept edge.
    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic              bin;
    } operands_t;

    // Signed overflow of a - b: operands differ in sign and the result
    // sign differs from the minuend.
    function automatic logic sub_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/sub_slice_8bit.sv
// Combinational 8-bit subtract slice: d = a + ~b + ~bin, with the borrow
// out reported as the inverted carry out.
module sub_slice_8bit
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] d,
    output logic               bout
);

    logic [SLICE_W:0] sum;

    assign sum  = {1'b0, a} + {1'b0, ~b} + {{SLICE_W{1'b0}}, ~bin};
    assign d    = sum[SLICE_W-1:0];
    assign bout = ~sum[SLICE_W];

endmodule

// File: rtl/subtractor_16bit_serial.sv
// Serial 16-bit subtractor: num_1 - num_2 - b_in, one byte per cycle through
// a shared 8-bit slice, with valid/ready handshakes and ALU status flags.
module subtractor_16bit_serial
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] num_1,
    input  logic [WORD_W-1:0] num_2,
    input  logic              b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] diff,
    output logic              borrow,
    output logic              zero,
    output logic              overflow
);

    state_t              state_q;
    state_t              state_d;
    operands_t           ops_q;

    logic [SLICE_W-1:0]  diff_lo_q;
    logic                borrow_lo_q;

    logic [WORD_W-1:0]   diff_q;
    logic                borrow_q;
    logic                zero_q;
    logic                overflow_q;

    logic [SLICE_W-1:0]  slice_a;
    logic [SLICE_W-1:0]  slice_b;
    logic                slice_bin;
    logic [SLICE_W-1:0]  slice_d;
    logic                slice_bout;
    logic [WORD_W-1:0]   full_diff;
    logic                accept;

    sub_slice_8bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .bin  (slice_bin),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // The slice output is only meaningful in HIGH, where it forms the upper byte.
    assign full_diff = {slice_d, diff_lo_q};
    assign accept    = in_valid & in_ready;

    // NOTE: every output of this block is given a default first so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        slice_a   = ops_q.a[SLICE_W-1:0];
        slice_b   = ops_q.b[SLICE_W-1:0];
        slice_bin = ops_q.bin;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                state_d = HIGH;
            end
            HIGH: begin
                slice_a   = ops_q.a[WORD_W-1:SLICE_W];
                slice_b   = ops_q.b[WORD_W-1:SLICE_W];
                slice_bin = borrow_lo_q;
                state_d   = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_q <= '0;
        end else if (accept) begin
            ops_q <= '{a: num_1, b: num_2, bin: b_in};
        end
    end

    // The low byte is kept internal so the visible diff changes only once,
    // when the whole word is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_lo_q   <= '0;
            borrow_lo_q <= 1'b0;
        end else if (state_q == LOW) begin
            diff_lo_q   <= slice_d;
            borrow_lo_q <= slice_bout;
        end
    end

    // NOTE: the result registers are reset because their reset values are
    // architecturally visible on the outputs; an abort must clear them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (state_q == HIGH) begin
            diff_q     <= full_diff;
            borrow_q   <= slice_bout;
            zero_q     <= (full_diff == '0);
            overflow_q <= sub_overflow(ops_q.a[WORD_W-1], ops_q.b[WORD_W-1],
                                       slice_d[SLICE_W-1]);
        end
    end

    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;

endmodule
